// File: rtl/ps2_pkg.sv
// Shared PS/2 receive definitions: controller states, frame geometry and the
// frame acceptance rule.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    CHECK,
    HOLD,
    ERROR,
    INHIBIT
  } ps2_rx_state_t;

  localparam int PS2_DATA_BITS  = 8;
  localparam int PS2_FRAME_TAIL = 10;

  // Tail layout after the start bit: [7:0] data LSB-first, [8] parity, [9] stop.
  function automatic logic ps2_frame_ok(input logic [PS2_FRAME_TAIL-1:0] tail);
    return (^tail[PS2_DATA_BITS:0]) & tail[PS2_FRAME_TAIL-1];
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for the PS/2 clock line with a one-cycle strobe on
// each synchronized high-to-low transition.
module ps2_line_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic line,
  output logic fall
);

  logic meta_reg;
  logic sync_reg;
  logic prev_reg;

  // Idle level of the line is high, so every stage resets to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_reg <= 1'b1;
      sync_reg <= 1'b1;
      prev_reg <= 1'b1;
    end else begin
      meta_reg <= line;
      sync_reg <= meta_reg;
      prev_reg <= sync_reg;
    end
  end

  assign fall = prev_reg & ~sync_reg;

endmodule

// File: rtl/ps2_rx_controller.sv
// PS/2 host receive controller: captures keyboard frames, validates parity and
// stop bit, and presents scan codes over valid/ready while inhibiting the keyboard.
module ps2_rx_controller
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 20000,
  parameter int INHIBIT_CYCLES = 5000
) (
  input  logic       sysClock,
  input  logic       sysResetN,
  input  logic       inKeyClk,
  input  logic       regInData,
  output logic       outKeyClk,
  output logic [7:0] scanCode,
  output logic       scanValid,
  input  logic       scanReady,
  output logic       frameError,
  output logic [7:0] errorCount
);

  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
  localparam int CNT_W = $clog2(PS2_FRAME_TAIL + 1);

  localparam logic [TO_W-1:0]  TIMEOUT_LIMIT = TO_W'(TIMEOUT_CYCLES);
  localparam logic [INH_W-1:0] INHIBIT_LAST  = INH_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STOP_BIT_IDX  = CNT_W'(PS2_FRAME_TAIL - 1);

  logic key_fall;
  logic data_meta_reg;
  logic data_sync_reg;

  ps2_rx_state_t               state_reg,       state_next;
  logic [CNT_W-1:0]            bit_cnt_reg,     bit_cnt_next;
  logic [PS2_FRAME_TAIL-1:0]   shift_reg,       shift_next;
  logic [TO_W-1:0]             timeout_reg,     timeout_next;
  logic [INH_W-1:0]            inhibit_reg,     inhibit_next;
  logic [PS2_DATA_BITS-1:0]    scan_code_reg,   scan_code_next;
  logic                        scan_valid_reg,  scan_valid_next;
  logic                        frame_error_reg, frame_error_next;
  logic [7:0]                  error_count_reg, error_count_next;
  logic                        key_inhibit_reg, key_inhibit_next;

  ps2_line_sync u_key_clk_sync (
    .clk   (sysClock),
    .rst_n (sysResetN),
    .line  (inKeyClk),
    .fall  (key_fall)
  );

  // Data needs only its synchronized level; it shares the clock's latency.
  always_ff @(posedge sysClock or negedge sysResetN) begin
    if (!sysResetN) begin
      data_meta_reg <= 1'b1;
      data_sync_reg <= 1'b1;
    end else begin
      data_meta_reg <= regInData;
      data_sync_reg <= data_meta_reg;
    end
  end

  always_ff @(posedge sysClock or negedge sysResetN) begin
    if (!sysResetN) begin
      state_reg       <= IDLE;
      bit_cnt_reg     <= '0;
      shift_reg       <= '0;
      timeout_reg     <= '0;
      inhibit_reg     <= '0;
      scan_code_reg   <= '0;
      scan_valid_reg  <= 1'b0;
      frame_error_reg <= 1'b0;
      error_count_reg <= '0;
      key_inhibit_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      bit_cnt_reg     <= bit_cnt_next;
      shift_reg       <= shift_next;
      timeout_reg     <= timeout_next;
      inhibit_reg     <= inhibit_next;
      scan_code_reg   <= scan_code_next;
      scan_valid_reg  <= scan_valid_next;
      frame_error_reg <= frame_error_next;
      error_count_reg <= error_count_next;
      key_inhibit_reg <= key_inhibit_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    bit_cnt_next     = bit_cnt_reg;
    shift_next       = shift_reg;
    timeout_next     = timeout_reg;
    inhibit_next     = inhibit_reg;
    scan_code_next   = scan_code_reg;
    scan_valid_next  = scan_valid_reg;
    error_count_next = error_count_reg;

    unique case (state_reg)
      IDLE: begin
        // A high data level on a falling edge is not a start bit; drop it quietly.
        if (key_fall && !data_sync_reg) begin
          state_next   = SHIFT;
          bit_cnt_next = '0;
          timeout_next = '0;
        end
      end
      SHIFT: begin
        if (key_fall) begin
          shift_next   = {data_sync_reg, shift_reg[PS2_FRAME_TAIL-1:1]};
          bit_cnt_next = bit_cnt_reg + 1'b1;
          timeout_next = '0;
          if (bit_cnt_reg == STOP_BIT_IDX) begin
            state_next = CHECK;
          end
        end else if (timeout_reg == TIMEOUT_LIMIT) begin
          state_next = ERROR;
        end else begin
          timeout_next = timeout_reg + 1'b1;
        end
      end
      CHECK: begin
        if (ps2_frame_ok(shift_reg)) begin
          scan_code_next  = shift_reg[PS2_DATA_BITS-1:0];
          scan_valid_next = 1'b1;
          state_next      = HOLD;
        end else begin
          state_next = ERROR;
        end
      end
      HOLD: begin
        if (scanReady) begin
          scan_valid_next = 1'b0;
          state_next      = IDLE;
        end
      end
      ERROR: begin
        if (error_count_reg != 8'hFF) begin
          error_count_next = error_count_reg + 8'd1;
        end
        shift_next   = '0;
        bit_cnt_next = '0;
        inhibit_next = '0;
        state_next   = INHIBIT;
      end
      INHIBIT: begin
        if (inhibit_reg == INHIBIT_LAST) begin
          state_next = IDLE;
        end else begin
          inhibit_next = inhibit_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Registered from the next state so they line up with the state itself.
    frame_error_next = (state_next == ERROR);
    key_inhibit_next = (state_next == HOLD) || (state_next == INHIBIT);
  end

  assign outKeyClk  = key_inhibit_reg;
  assign scanCode   = scan_code_reg;
  assign scanValid  = scan_valid_reg;
  assign frameError = frame_error_reg;
  assign errorCount = error_count_reg;

endmodule
